reg_arbiter: RTL and testbench
==============================

REG_ARBITER -- requirements
Module: reg_arbiter

Interface
REQ-001 Parameter WIDTH, default 32, data width of each bank register (signed).
REQ-002 Parameter NREQ, default 4, number of write requesters (2..8).
REQ-003 Parameter DEPTH, default 8, number of bank registers; power of two only.
REQ-004 Parameter AW, default 3, address width, equal to log2(DEPTH).
REQ-005 Port clk, input, 1, clock; all state updates on its rising edge.
REQ-006 Port rst, input, 1, reset; synchronous, active-high.
REQ-007 Port req_valid, input, NREQ, bit i set means requester i presents a write.
REQ-008 Port req_addr, input, NREQ*AW, flattened; slice i is the target register of requester i.
REQ-009 Port req_data, input, NREQ*WIDTH, flattened signed; slice i is the write data of requester i.
REQ-010 Port req_ready, output, NREQ, one-hot or zero; bit i set means requester i is granted this cycle.
REQ-011 Port rd_addr, input, AW, read address.
REQ-012 Port rd_data, output, WIDTH, signed registered read data.
REQ-013 Port grant_id, output, 3, index of the last granted requester.
REQ-014 Port wr_count, output, 16, saturating count of accepted writes.

Function
REQ-015 A write transfer from requester i occurs on a rising edge where req_valid[i] and req_ready[i] are both high.
REQ-016 req_ready is combinational from req_valid and the priority pointer; at most one bit is set per cycle.
REQ-017 Arbitration is round-robin: search starts at index ptr and wraps from NREQ-1 to 0; the first requester with valid set is granted.
REQ-018 After a transfer by requester i, ptr becomes (i+1) mod NREQ; with no transfer, ptr holds.
REQ-019 A granted write updates bank[req_addr slice i] with req_data slice i on the same edge; all other registers hold.
REQ-020 rd_data is loaded with bank[rd_addr] on every edge (1-cycle read latency).
REQ-021 No bypass: a read and a write to the same address in one cycle return the old value; the new value appears on the following cycle.
REQ-022 grant_id is loaded with i on each transfer and holds otherwise.
REQ-023 wr_count increments by 1 per transfer and saturates at 16'hFFFF.
REQ-024 Requesters must hold valid, addr and data stable until ready; a dropped valid is not an error and causes no write.
REQ-025 With req_valid all zero, req_ready is all zero and no state other than rd_data changes.

Reset
REQ-026 While rst is high: all bank registers, rd_data, grant_id and wr_count clear to 0; ptr clears to 0.
REQ-027 req_ready is forced to all zero while rst is high; no write is accepted in a reset cycle.
REQ-028 Reset asserted mid-stream discards any in-flight request; arbitration restarts from requester 0 on the first cycle after rst falls.

Structure
REQ-029 Default parameter values (NREQ, DEPTH, AW) and the counter width of 16 are defined in the shared package arb_pkg, which reg_arbiter uses.
REQ-030 Each bank entry is an instance of the existing register sub-module, with en driven by the decoded grant and address and rst shared.
REQ-031 Round-robin selection is implemented once as a function or generate block; it is not duplicated per requester.

Verification
REQ-032 Reset, then all 4 requesters valid continuously with distinct addresses -> grants in order 0,1,2,3,0; wr_count = 5 after 5 cycles.
REQ-033 Only requester 2 valid, addr 5, data -7 -> req_ready = 4'b0100 in the same cycle; rd_addr 5 reads -7 one cycle after the write edge.
REQ-034 Requesters 1 and 3 both write addr 0, with ptr = 2 -> 3 is granted first, then 1; bank[0] ends with the data from requester 1.
REQ-035 Write and read to addr 6 in the same cycle, old value 0, new value 9 -> rd_data = 0, then 9 on the next cycle.
REQ-036 Force wr_count to 16'hFFFE, then perform 3 writes -> wr_count = 16'hFFFF and holds.
REQ-037 Assert rst for 1 cycle during continuous traffic -> req_ready = 0 and all outputs = 0 in that cycle; requester 0 is granted first after rst falls.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared defaults and the round-robin pick helper
// for the register-bank write arbiter.
package arb_pkg;

  localparam int NREQ_DEF  = 4;
  localparam int DEPTH_DEF = 8;
  localparam int AW_DEF    = 3;
  localparam int CNT_W     = 16;

  // Returns {found, index}; search starts at p and wraps at n.
  function automatic logic [3:0] rr_pick(
    input logic [7:0] v,
    input int         n,
    input logic [2:0] p
  );
    logic [3:0] r;
    int         j;
    r = '0;
    for (int k = n - 1; k >= 0; k--) begin
      j = (int'(p) + k) % n;
      if (v[3'(j)]) r = {1'b1, 3'(j)};
    end
    return r;
  endfunction

endpackage

// File: rtl/reg_arbiter_reg.sv
// One bank register: synchronous clear,
// load on enable.
module reg_arbiter_reg #(
  parameter int WIDTH = 32
)(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic signed [WIDTH-1:0] d,
  output logic signed [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst)     q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/reg_arbiter.sv
// Round-robin arbiter granting NREQ writers
// access to a bank of registers.
module reg_arbiter
  import arb_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NREQ  = NREQ_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = AW_DEF
)(
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NREQ-1:0]              req_valid,
  input  logic [NREQ*AW-1:0]           req_addr,
  input  logic signed [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]              req_ready,
  input  logic [AW-1:0]                rd_addr,
  output logic signed [WIDTH-1:0]      rd_data,
  output logic [2:0]                   grant_id,
  output logic [CNT_W-1:0]             wr_count
);

  logic [2:0]              ptr_q, ptr_d;
  logic [2:0]              gid_q, gid_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic signed [WIDTH-1:0] rd_q;
  logic signed [WIDTH-1:0] bank_q [DEPTH];

  logic [7:0]              vld_ext;
  logic [3:0]              pick;
  logic [2:0]              gidx;
  logic                    xfer;
  logic [AW-1:0]           waddr;
  logic signed [WIDTH-1:0] wdata;

  always_comb begin
    vld_ext = '0;
    vld_ext[NREQ-1:0] = req_valid;
    pick  = rr_pick(vld_ext, NREQ, ptr_q);
    gidx  = pick[2:0];
    xfer  = pick[3] && !rst;
    req_ready = '0;
    if (xfer) req_ready = NREQ'(1) << gidx;
    waddr = req_addr[int'(gidx)*AW +: AW];
    wdata = req_data[int'(gidx)*WIDTH +: WIDTH];
  end

  always_comb begin
    ptr_d = ptr_q;
    gid_d = gid_q;
    cnt_d = cnt_q;
    if (xfer) begin
      ptr_d = (int'(gidx) == NREQ - 1) ? 3'd0 : gidx + 3'd1;
      gid_d = gidx;
      if (cnt_q != '1) cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
      gid_q <= '0;
      cnt_q <= '0;
      rd_q  <= '0;
    end else begin
      ptr_q <= ptr_d;
      gid_q <= gid_d;
      cnt_q <= cnt_d;
      rd_q  <= bank_q[rd_addr];
    end
  end

  for (genvar j = 0; j < DEPTH; j++) begin : g_bank
    reg_arbiter_reg #(.WIDTH(WIDTH)) u_reg (
      .clk (clk),
      .rst (rst),
      .en  (xfer && (waddr == AW'(j))),
      .d   (wdata),
      .q   (bank_q[j])
    );
  end

  assign rd_data  = rd_q;
  assign grant_id = gid_q;
  assign wr_count = cnt_q;

endmodule

// File: tb/tb_reg_arbiter.sv
// Directed bench for reg_arbiter with a
// per-cycle reference model.
module tb_reg_arbiter;

  localparam int W  = 32;
  localparam int N  = 4;
  localparam int D  = 8;
  localparam int AW = 3;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic [N-1:0]             req_valid = '0;
  logic [N*AW-1:0]          req_addr  = '0;
  logic signed [N*W-1:0]    req_data  = '0;
  logic [N-1:0]             req_ready;
  logic [AW-1:0]            rd_addr   = '0;
  logic signed [W-1:0]      rd_data;
  logic [2:0]               grant_id;
  logic [15:0]              wr_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  reg_arbiter #(.WIDTH(W), .NREQ(N), .DEPTH(D), .AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .grant_id  (grant_id),
    .wr_count  (wr_count)
  );

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h @%0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic set_req(input int i,
                         input int a,
                         input int dv);
    req_addr[i*AW +: AW] = AW'(a);
    req_data[i*W +: W]   = W'(dv);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: state after each edge.
  logic signed [W-1:0] m_bank [D];
  logic signed [W-1:0] m_rd;
  int                  m_ptr;
  int                  m_gid;
  int                  m_cnt;

  initial begin
    logic [N-1:0] er;
    int           gi;
    bit           hit;
    foreach (m_bank[k]) m_bank[k] = '0;
    m_rd = '0; m_ptr = 0; m_gid = 0; m_cnt = 0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      er = '0; gi = 0; hit = 0;
      if (!rst)
        for (int k = 0; k < N; k++) begin
          if (!hit && req_valid[(m_ptr + k) % N]) begin
            hit = 1;
            gi  = (m_ptr + k) % N;
            er[gi] = 1'b1;
          end
        end
      chk("m_ready", 64'(req_ready), 64'(er));
      chk("m_rd", 64'(rd_data), 64'(m_rd));
      chk("m_gid", 64'(grant_id), 64'(m_gid));
      chk("m_cnt", 64'(wr_count), 64'(m_cnt));
      if (rst) begin
        foreach (m_bank[k]) m_bank[k] = '0;
        m_rd = '0; m_ptr = 0; m_gid = 0; m_cnt = 0;
      end else begin
        m_rd = m_bank[rd_addr];
        if (hit) begin
          m_bank[req_addr[gi*AW +: AW]] = req_data[gi*W +: W];
          m_gid = gi;
          m_ptr = (gi + 1) % N;
          if (m_cnt < 65535) m_cnt++;
        end
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_cnt", 64'(wr_count), 64'd0);
    chk("rst_rd", 64'(rd_data), 64'd0);

    // All four requesters, distinct addresses
    tick();
    rst = 1'b0;
    for (int i = 0; i < N; i++) set_req(i, i + 1, 100 + i);
    req_valid = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("rr_order", 64'(req_ready), 64'(1) << (c % 4));
      tick();
    end
    req_valid = '0;
    @(negedge clk);
    chk("rr_cnt5", 64'(wr_count), 64'd5);
    chk("rr_gid", 64'(grant_id), 64'd0);
    chk("idle_ready", 64'(req_ready), 64'd0);

    // Lone requester 2, addr 5, data -7
    tick();
    set_req(2, 5, -7);
    req_valid = 4'b0100;
    rd_addr = 3'd5;
    @(negedge clk);
    chk("r2_ready", 64'(req_ready), 64'b0100);
    tick();
    req_valid = '0;
    @(negedge clk);
    chk("r2_old", 64'(rd_data), 64'd0);
    tick();
    @(negedge clk);
    chk("r2_new", 64'(rd_data), 64'($signed(-7)));

    // Move ptr to 2, then 1 and 3 contend
    tick();
    set_req(1, 7, 11);
    req_valid = 4'b0010;
    @(negedge clk);
    chk("p_setup", 64'(req_ready), 64'b0010);
    tick();
    set_req(1, 0, 'h111);
    set_req(3, 0, 'h333);
    req_valid = 4'b1010;
    @(negedge clk);
    chk("c_first3", 64'(req_ready), 64'b1000);
    tick();
    req_valid = 4'b0010;
    @(negedge clk);
    chk("c_then1", 64'(req_ready), 64'b0010);
    tick();
    req_valid = '0;
    rd_addr = 3'd0;
    tick();
    @(negedge clk);
    chk("c_bank0", 64'(rd_data), 64'h111);

    // Same-cycle write and read of addr 6
    tick();
    set_req(0, 6, 9);
    req_valid = 4'b0001;
    rd_addr = 3'd6;
    tick();
    req_valid = '0;
    @(negedge clk);
    chk("nb_old", 64'(rd_data), 64'd0);
    tick();
    @(negedge clk);
    chk("nb_new", 64'(rd_data), 64'd9);

    // Reset pulse in the middle of traffic
    tick();
    for (int i = 0; i < N; i++) set_req(i, i + 1, 200 + i);
    req_valid = 4'b1111;
    repeat (3) tick();
    rst = 1'b1;
    @(negedge clk);
    chk("mr_ready", 64'(req_ready), 64'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("mr_first", 64'(req_ready), 64'b0001);
    chk("mr_cnt", 64'(wr_count), 64'd0);
    chk("mr_gid", 64'(grant_id), 64'd0);
    chk("mr_rd", 64'(rd_data), 64'd0);
    tick();
    @(negedge clk);
    chk("mr_cnt1", 64'(wr_count), 64'd1);
    chk("mr_next", 64'(req_ready), 64'b0010);

    // Counter saturation
    tick();
    rst = 1'b1;
    req_valid = '0;
    tick();
    rst = 1'b0;
    req_valid = 4'b0001;
    repeat (65534) tick();
    @(negedge clk);
    chk("sat_fffe", 64'(wr_count), 64'hFFFE);
    repeat (3) tick();
    @(negedge clk);
    chk("sat_ffff", 64'(wr_count), 64'hFFFF);
    req_valid = '0;
    tick();
    @(negedge clk);
    chk("sat_hold", 64'(wr_count), 64'hFFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
